// File: rtl/convolution_controller.sv
// 3x3 convolution engine: AXI4-Lite-style register file, column-ordered pixel
// stream in, one multiply-accumulated window result per output pixel out.
module convolution_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int KERNEL     = 3
) (
    input  logic                      axi_clk,
    input  logic                      axi_reset,
    input  logic                      s_axis_valid,
    input  logic [DATA_WIDTH-1:0]     s_axis_data,
    output logic                      s_axis_ready,
    input  logic                      s_axis_last,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_keep,
    output logic                      m_axis_valid,
    output logic [DATA_WIDTH-1:0]     m_axis_data,
    input  logic                      m_axis_ready,
    output logic                      m_axis_last,
    output logic [DATA_WIDTH/8-1:0]   m_axis_keep,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int TAPS = KERNEL * KERNEL;
    localparam logic [ADDR_WIDTH-1:0] WIDTH_ADDR   = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] HEIGHT_ADDR  = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] CONTROL_ADDR = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR  = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] RESULT_ADDR  = ADDR_WIDTH'(8'h10);
    localparam int FILTER_BASE = 'h14;

    typedef enum logic [2:0] {IDLE, FILL, CALC, OUT, GAP} state_t;

    state_t state, next_state;

    logic [DATA_WIDTH-1:0] reg_width, reg_height, last_result;
    logic                  enable, frame_done;
    logic [DATA_WIDTH-1:0] filter [TAPS];
    logic [DATA_WIDTH-1:0] win [TAPS];
    logic [DATA_WIDTH-1:0] frame_w, frame_h, col, row, acc;
    logic [3:0]            need, tap;
    logic [DATA_WIDTH-1:0] read_value;
    logic                  wr_en, accept, frame_start, col_more, row_more, busy;

    // Stream sideband is not used: frame boundaries come from the counters.
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_last, s_axis_keep};

    assign s_axi_awready = 1'b1;
    assign s_axi_wready  = 1'b1;
    assign s_axi_arready = 1'b1;

    assign wr_en       = s_axi_awvalid && s_axi_wvalid;
    assign accept      = s_axis_valid && s_axis_ready;
    assign frame_start = (state == IDLE) && enable &&
                         (reg_width >= DATA_WIDTH'(3)) && (reg_height >= DATA_WIDTH'(3));
    assign col_more    = col < (frame_w - DATA_WIDTH'(3));
    assign row_more    = row < (frame_h - DATA_WIDTH'(3));
    assign busy        = (state != IDLE);

    always_ff @(posedge axi_clk) begin
        if (axi_reset) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (frame_start) next_state = FILL;
            FILL: if (accept && need == 4'd1) next_state = CALC;
            CALC: if (tap == 4'(TAPS - 1)) next_state = OUT;
            OUT:  if (m_axis_ready) next_state = GAP;
            GAP:  next_state = (col_more || row_more) ? FILL : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        m_axis_last  = 1'b0;
        m_axis_keep  = '0;
        case (state)
            FILL: s_axis_ready = 1'b1;
            OUT: begin
                m_axis_valid = 1'b1;
                m_axis_data  = acc;
                m_axis_keep  = '1;
                m_axis_last  = (row == frame_h - DATA_WIDTH'(3)) &&
                               (col == frame_w - DATA_WIDTH'(3));
            end
            default: ;
        endcase
    end

    // Register file plus the window/accumulator datapath; frame_done is set
    // after the CONTROL-write clear so a coincident frame end is not lost.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            reg_width   <= '0;
            reg_height  <= '0;
            enable      <= 1'b0;
            frame_done  <= 1'b0;
            last_result <= '0;
            frame_w     <= '0;
            frame_h     <= '0;
            col         <= '0;
            row         <= '0;
            acc         <= '0;
            need        <= '0;
            tap         <= '0;
            for (int i = 0; i < TAPS; i++) begin
                filter[i] <= '0;
                win[i]    <= '0;
            end
        end else begin
            if (wr_en) begin
                case (s_axi_awaddr)
                    WIDTH_ADDR:  reg_width  <= s_axi_wdata;
                    HEIGHT_ADDR: reg_height <= s_axi_wdata;
                    CONTROL_ADDR: begin
                        enable     <= s_axi_wdata[0];
                        frame_done <= 1'b0;
                    end
                    default: ;
                endcase
                for (int i = 0; i < TAPS; i++)
                    if (s_axi_awaddr == ADDR_WIDTH'(FILTER_BASE + 4 * i))
                        filter[i] <= s_axi_wdata;
            end
            case (state)
                IDLE: if (frame_start) begin
                    frame_w <= reg_width;
                    frame_h <= reg_height;
                    need    <= 4'(TAPS);
                    col     <= '0;
                    row     <= '0;
                end
                FILL: if (accept) begin
                    for (int k = 0; k < TAPS - 1; k++) win[k] <= win[k + 1];
                    win[TAPS-1] <= s_axis_data;
                    need        <= need - 4'd1;
                    if (need == 4'd1) begin
                        tap <= '0;
                        acc <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + filter[tap] * win[tap];
                    tap <= tap + 4'd1;
                end
                OUT: if (m_axis_ready) last_result <= acc;
                GAP: begin
                    if (col_more) begin
                        col  <= col + DATA_WIDTH'(1);
                        need <= 4'(KERNEL);
                    end else if (row_more) begin
                        row  <= row + DATA_WIDTH'(1);
                        col  <= '0;
                        need <= 4'(TAPS);
                    end else begin
                        frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        read_value = '0;
        case (s_axi_araddr)
            WIDTH_ADDR:   read_value = reg_width;
            HEIGHT_ADDR:  read_value = reg_height;
            CONTROL_ADDR: read_value = DATA_WIDTH'(enable);
            STATUS_ADDR:  read_value = DATA_WIDTH'({frame_done, busy});
            RESULT_ADDR:  read_value = last_result;
            default: ;
        endcase
        for (int i = 0; i < TAPS; i++)
            if (s_axi_araddr == ADDR_WIDTH'(FILTER_BASE + 4 * i))
                read_value = filter[i];
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else begin
            if (wr_en)             s_axi_bvalid <= 1'b1;
            else if (s_axi_bready) s_axi_bvalid <= 1'b0;
            if (s_axi_arvalid) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= read_value;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_convolution_controller.sv
// Scoreboard bench for convolution_controller: stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
module tb_convolution_controller;

    logic        axi_clk = 1'b0;
    logic        axi_reset;
    logic        s_axis_valid, s_axis_ready, s_axis_last;
    logic [31:0] s_axis_data;
    logic [3:0]  s_axis_keep;
    logic        m_axis_valid, m_axis_ready, m_axis_last;
    logic [31:0] m_axis_data;
    logic [3:0]  m_axis_keep;
    logic [9:0]  s_axi_awaddr, s_axi_araddr;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] img [10][10];
    logic [31:0] rd;

    localparam logic [9:0] WIDTH_A = 10'h00, HEIGHT_A = 10'h04, CONTROL_A = 10'h08;
    localparam logic [9:0] STATUS_A = 10'h0C, RESULT_A = 10'h10, FILTER_A = 10'h14;

    always #5 axi_clk = ~axi_clk;

    convolution_controller dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset),
        .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready),
        .s_axis_last(s_axis_last), .s_axis_keep(s_axis_keep),
        .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_ready(m_axis_ready),
        .m_axis_last(m_axis_last), .m_axis_keep(m_axis_keep),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pix);
        int waited = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = pix;
        while (!s_axis_ready && waited < 1000) begin
            @(posedge axi_clk); #1;
            waited++;
        end
        if (!s_axis_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL pixel_accept: got timeout, expected ready within 1000 cycles");
        end
        @(posedge axi_clk); #1;
        s_axis_valid = 1'b0;
    endtask

    task automatic axi_write(input logic [9:0] addr, input logic [31:0] data);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        @(posedge axi_clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        checkOutput("bvalid_set", 32'(s_axi_bvalid), 1);
        @(posedge axi_clk); #1;
        checkOutput("bvalid_clear", 32'(s_axi_bvalid), 0);
    endtask

    task automatic axi_read(input logic [9:0] addr, output logic [31:0] data);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        @(posedge axi_clk); #1;
        s_axi_arvalid = 1'b0;
        checkOutput("rvalid_set", 32'(s_axi_rvalid), 1);
        data = s_axi_rdata;
        @(posedge axi_clk); #1;
    endtask

    task automatic read_check(input string name, input logic [9:0] addr,
                              input logic [31:0] expected);
        logic [31:0] value;
        axi_read(addr, value);
        checkOutput(name, value, expected);
    endtask

    task automatic write_filters();
        for (int i = 0; i < 9; i++) axi_write(FILTER_A + 10'(4 * i), 32'(i));
    endtask

    // Leaves enable cleared once the frame has left IDLE, so exactly one frame runs.
    task automatic start_frame();
        axi_write(CONTROL_A, 32'd1);
        axi_write(CONTROL_A, 32'd0);
    endtask

    task automatic push_expected(input logic [31:0] data, input logic last);
        exp_t e;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge axi_clk); #1;
            n++;
        end
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(posedge axi_clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        checkOutput("rst_s_ready", 32'(s_axis_ready), 0);
        checkOutput("rst_m_valid", 32'(m_axis_valid), 0);
        checkOutput("rst_m_data", m_axis_data, 0);
        checkOutput("rst_m_last", 32'(m_axis_last), 0);
        checkOutput("rst_m_keep", 32'(m_axis_keep), 0);
        checkOutput("rst_bvalid", 32'(s_axi_bvalid), 0);
        checkOutput("rst_rvalid", 32'(s_axi_rvalid), 0);
        checkOutput("rst_rdata", s_axi_rdata, 0);
        checkOutput("rst_awready", 32'(s_axi_awready), 1);
        checkOutput("rst_wready", 32'(s_axi_wready), 1);
        checkOutput("rst_arready", 32'(s_axi_arready), 1);
    endtask

    // Reference result from image geometry: column c+j, row r+k, tap 3j+k, FILTER[i]=i.
    function automatic logic [31:0] window_result(input int r, input int c);
        logic [31:0] sum = 0;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                sum = sum + 32'(3 * j + k) * img[r + k][c + j];
        return sum;
    endfunction

    // Streams output rows r0..r1 column by column, three pixels per column.
    task automatic send_stream(input int w, input int r0, input int r1, input int max_px);
        int sent = 0;
        for (int r = r0; r <= r1; r++)
            for (int c = 0; c < w; c++)
                for (int k = 0; k < 3; k++) begin
                    if (sent < max_px) applyStimulus(img[r + k][c]);
                    sent++;
                end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge axi_clk);
            if (m_axis_valid) checkOutput("s_ready_low_while_pending", 32'(s_axis_ready), 0);
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got data %0d, expected no output",
                             m_axis_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result_data", m_axis_data, e.data);
                    checkOutput("result_last", 32'(m_axis_last), 32'(e.last));
                    checkOutput("result_keep", 32'(m_axis_keep), 32'hF);
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        axi_reset     = 1'b1;
        s_axis_valid  = 1'b0;
        s_axis_data   = '0;
        s_axis_last   = 1'b0;
        s_axis_keep   = 4'hF;
        m_axis_ready  = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        repeat (3) @(posedge axi_clk);
        #1;
        check_reset_outputs();
        axi_reset = 1'b0;

        $display("[TB] register readback");
        axi_write(WIDTH_A, 32'd10);
        axi_write(HEIGHT_A, 32'd10);
        write_filters();
        read_check("rd_width", WIDTH_A, 10);
        read_check("rd_height", HEIGHT_A, 10);
        for (int i = 0; i < 9; i++) read_check("rd_filter", FILTER_A + 10'(4 * i), 32'(i));
        read_check("rd_unmapped_38", 10'h038, 0);
        read_check("rd_unmapped_3fc", 10'h3FC, 0);
        read_check("rd_status_idle", STATUS_A, 0);

        $display("[TB] 3x3 frame");
        axi_write(WIDTH_A, 32'd3);
        axi_write(HEIGHT_A, 32'd3);
        start_frame();
        push_expected(32'd240, 1'b1);
        for (int p = 1; p <= 9; p++) applyStimulus(32'(p));
        wait_drain();
        read_check("status_frame_done", STATUS_A, 2);
        read_check("last_result_240", RESULT_A, 240);

        $display("[TB] backpressure");
        m_axis_ready = 1'b0;
        start_frame();
        push_expected(32'd120, 1'b1);
        for (int p = 9; p >= 1; p--) applyStimulus(32'(p));
        n = 0;
        while (!m_axis_valid && n < 100) begin
            @(posedge axi_clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid_held", 32'(m_axis_valid), 1);
            checkOutput("bp_data_held", m_axis_data, 120);
            checkOutput("bp_s_ready_low", 32'(s_axis_ready), 0);
            @(posedge axi_clk); #1;
        end
        m_axis_ready = 1'b1;
        wait_drain();
        read_check("last_result_120", RESULT_A, 120);

        $display("[TB] 10x10 frame");
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) img[r][c] = 32'($urandom_range(0, 65535));
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) push_expected(window_result(r, c), r == 7 && c == 7);
        axi_write(WIDTH_A, 32'd10);
        axi_write(HEIGHT_A, 32'd10);
        start_frame();
        send_stream(10, 0, 7, 1000);
        wait_drain();
        read_check("status_10x10_done", STATUS_A, 2);
        read_check("last_result_10x10", RESULT_A, window_result(7, 7));

        $display("[TB] disabled and misconfigured");
        s_axis_valid = 1'b1;
        s_axis_data  = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(posedge axi_clk); #1;
            checkOutput("disabled_s_ready", 32'(s_axis_ready), 0);
            checkOutput("disabled_m_valid", 32'(m_axis_valid), 0);
        end
        axi_write(WIDTH_A, 32'd2);
        axi_write(CONTROL_A, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge axi_clk); #1;
            checkOutput("narrow_s_ready", 32'(s_axis_ready), 0);
            checkOutput("narrow_m_valid", 32'(m_axis_valid), 0);
        end
        read_check("narrow_status_idle", STATUS_A, 0);
        axi_write(CONTROL_A, 32'd0);
        s_axis_valid = 1'b0;

        $display("[TB] reset mid-frame");
        axi_write(WIDTH_A, 32'd10);
        for (int c = 0; c < 4; c++) push_expected(window_result(0, c), 1'b0);
        axi_write(CONTROL_A, 32'd1);
        send_stream(10, 0, 0, 20);
        wait_drain();
        axi_reset = 1'b1;
        repeat (2) @(posedge axi_clk);
        #1;
        check_reset_outputs();
        axi_reset = 1'b0;
        read_check("post_rst_width", WIDTH_A, 0);
        read_check("post_rst_height", HEIGHT_A, 0);
        read_check("post_rst_control", CONTROL_A, 0);
        read_check("post_rst_filter4", FILTER_A + 10'd16, 0);
        read_check("post_rst_result", RESULT_A, 0);
        read_check("post_rst_status", STATUS_A, 0);
        axi_write(WIDTH_A, 32'd3);
        axi_write(HEIGHT_A, 32'd3);
        write_filters();
        start_frame();
        push_expected(32'd240, 1'b1);
        for (int p = 1; p <= 9; p++) applyStimulus(32'(p));
        wait_drain();
        read_check("post_rst_last_result", RESULT_A, 240);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
